// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared definitions for the scoring input conditioner.
//   state_t     : conditioner FSM states (NORMAL, CONVERSION)
//   EVT_*       : bit index of each scoring event in the request/grant vectors.
//                 Indices follow arbitration priority: index 0 wins over all
//                 higher indices (touchdown > extraPoint > twoPointConversion
//                 > fieldGoal > safety).
//   legal_mask  : events that may be accepted in a given state
//   first_one   : one-hot of the highest-priority (lowest-index) set bit
// -----------------------------------------------------------------------------
package score_pkg;

    typedef enum logic {
        NORMAL     = 1'b0,
        CONVERSION = 1'b1
    } state_t;

    localparam int NUM_EVT = 5;
    localparam int EVT_TD  = 0;
    localparam int EVT_XP  = 1;
    localparam int EVT_TP  = 2;
    localparam int EVT_FG  = 3;
    localparam int EVT_SF  = 4;

    function automatic logic [NUM_EVT-1:0] legal_mask(input state_t s);
        logic [NUM_EVT-1:0] m;
        m = '0;
        if (s == NORMAL) begin
            m[EVT_TD] = 1'b1;
            m[EVT_FG] = 1'b1;
            m[EVT_SF] = 1'b1;
        end else begin
            m[EVT_XP] = 1'b1;
            m[EVT_TP] = 1'b1;
        end
        return m;
    endfunction

    // Scanning from the lowest priority upward leaves the highest-priority
    // set bit as the only survivor.
    function automatic logic [NUM_EVT-1:0] first_one(input logic [NUM_EVT-1:0] v);
        logic [NUM_EVT-1:0] r;
        r = '0;
        for (int i = NUM_EVT - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Two-flop synchronizer, stability counter and stable level for one raw
// pushbutton. Emits a one-cycle pulse when the stable level rises.
//   clock  : rising-edge clock
//   rst_n  : active-low reset (already synchronized on deassertion)
//   i_btn  : raw asynchronous button, active-high
//   o_rise : registered pulse, high in the cycle the stable level becomes 1
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_rise
);

    localparam int           CW   = $clog2(DEBOUNCE_CYCLES + 1);
    // Toggling on the edge that would take the count to DEBOUNCE_CYCLES
    // means the counter never actually holds that value.
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_rise;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_rise   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            r_rise <= 1'b0;
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
                // Only a 0->1 change of the stable level is a request.
                r_rise   <= ~r_stable;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/score_input_conditioner.sv
// -----------------------------------------------------------------------------
// score_input_conditioner
// Debounces five scoring pushbuttons, filters presses that are illegal in the
// current game phase, arbitrates simultaneous presses and issues one-cycle
// scoring pulses.
//   clock                    : rising-edge clock
//   reset                    : asynchronous active-low reset
//   btn_*                    : raw pushbuttons, active-high
//   touchdown .. safety      : registered one-hot scoring pulses
//   conversion_pending       : high while only a conversion attempt is legal
//   rejected                 : pulse when presses were all illegal
// -----------------------------------------------------------------------------
module score_input_conditioner
    import score_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_touchdown,
    input  logic btn_extra_point,
    input  logic btn_two_point,
    input  logic btn_field_goal,
    input  logic btn_safety,
    output logic touchdown,
    output logic extraPoint,
    output logic twoPointConversion,
    output logic fieldGoal,
    output logic safety,
    output logic conversion_pending,
    output logic rejected
);

    // Reset asserts asynchronously but releases on a clock edge, so every
    // downstream flop leaves reset together.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    logic [NUM_EVT-1:0] w_btn;
    logic [NUM_EVT-1:0] w_req;

    assign w_btn[EVT_TD] = btn_touchdown;
    assign w_btn[EVT_XP] = btn_extra_point;
    assign w_btn[EVT_TP] = btn_two_point;
    assign w_btn[EVT_FG] = btn_field_goal;
    assign w_btn[EVT_SF] = btn_safety;

    generate
        for (genvar gi = 0; gi < NUM_EVT; gi++) begin : g_deb
            button_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clock (clock),
                .rst_n (w_rst_n),
                .i_btn (w_btn[gi]),
                .o_rise(w_req[gi])
            );
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_next;
    logic [NUM_EVT-1:0] w_legal;
    logic [NUM_EVT-1:0] w_grant;
    logic               w_reject;

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= NORMAL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_legal      = legal_mask(r_state);
        // Illegal presses are removed before arbitration; lower legal
        // presses lose and are simply dropped.
        w_grant      = first_one(w_req & w_legal);
        w_reject     = (|(w_req & ~w_legal)) && !(|w_grant);
        w_state_next = r_state;
        case (r_state)
            NORMAL: begin
                if (w_grant[EVT_TD]) begin
                    w_state_next = CONVERSION;
                end
            end
            CONVERSION: begin
                if (w_grant[EVT_XP] || w_grant[EVT_TP]) begin
                    w_state_next = NORMAL;
                end
            end
            default: w_state_next = NORMAL;
        endcase
    end

    logic [NUM_EVT-1:0] r_pulse;
    logic               r_rejected;

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pulse    <= '0;
            r_rejected <= 1'b0;
        end else begin
            r_pulse    <= w_grant;
            r_rejected <= w_reject;
        end
    end

    assign touchdown          = r_pulse[EVT_TD];
    assign extraPoint         = r_pulse[EVT_XP];
    assign twoPointConversion = r_pulse[EVT_TP];
    assign fieldGoal          = r_pulse[EVT_FG];
    assign safety             = r_pulse[EVT_SF];
    // r_state is itself a flop, so this flag changes on the same edge as the
    // touchdown pulse that caused the transition.
    assign conversion_pending = (r_state == CONVERSION);
    assign rejected           = r_rejected;

endmodule

// File: tb/tb_score_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_score_input_conditioner
// Directed bench for score_input_conditioner with DEBOUNCE_CYCLES = 4.
// Edge numbering: after inputs change just past a rising edge, the next rising
// edge is edge 1 (the first raw sampling edge). A clean press then shows its
// output pulse after edge 2 + 4 + 1 = 7. After reset release, the internal
// reset synchronizer spends two edges first, so a held button pulses after
// edge 9 counted from the release.
// -----------------------------------------------------------------------------
module tb_score_input_conditioner;

    logic clock = 1'b0;
    logic reset;
    logic btn_touchdown, btn_extra_point, btn_two_point, btn_field_goal, btn_safety;
    logic touchdown, extraPoint, twoPointConversion, fieldGoal, safety;
    logic conversion_pending, rejected;

    always #5 clock = ~clock;

    score_input_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .btn_touchdown     (btn_touchdown),
        .btn_extra_point   (btn_extra_point),
        .btn_two_point     (btn_two_point),
        .btn_field_goal    (btn_field_goal),
        .btn_safety        (btn_safety),
        .touchdown         (touchdown),
        .extraPoint        (extraPoint),
        .twoPointConversion(twoPointConversion),
        .fieldGoal         (fieldGoal),
        .safety            (safety),
        .conversion_pending(conversion_pending),
        .rejected          (rejected)
    );

    int n_checks = 0;
    int n_errors = 0;

    int edge_idx;
    int n_td, n_xp, n_tp, n_fg, n_sf, n_rej;
    int e_td, e_xp, e_tp, e_fg, e_sf, e_rej, e_cp;
    int n_multi = 0;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int outs_vec();
        return int'({touchdown, extraPoint, twoPointConversion, fieldGoal,
                     safety, conversion_pending, rejected});
    endfunction

    task automatic clear_counts();
        edge_idx = 0;
        n_td = 0; n_xp = 0; n_tp = 0; n_fg = 0; n_sf = 0; n_rej = 0;
        e_td = 0; e_xp = 0; e_tp = 0; e_fg = 0; e_sf = 0; e_rej = 0; e_cp = 0;
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            edge_idx++;
            if (touchdown)          begin n_td++;  if (e_td  == 0) e_td  = edge_idx; end
            if (extraPoint)         begin n_xp++;  if (e_xp  == 0) e_xp  = edge_idx; end
            if (twoPointConversion) begin n_tp++;  if (e_tp  == 0) e_tp  = edge_idx; end
            if (fieldGoal)          begin n_fg++;  if (e_fg  == 0) e_fg  = edge_idx; end
            if (safety)             begin n_sf++;  if (e_sf  == 0) e_sf  = edge_idx; end
            if (rejected)           begin n_rej++; if (e_rej == 0) e_rej = edge_idx; end
            if (conversion_pending && e_cp == 0) e_cp = edge_idx;
            if ((int'(touchdown) + int'(extraPoint) + int'(twoPointConversion)
                 + int'(fieldGoal) + int'(safety)) > 1) n_multi++;
        end
    endtask

    task automatic release_all();
        btn_touchdown = 0; btn_extra_point = 0; btn_two_point = 0;
        btn_field_goal = 0; btn_safety = 0;
        clear_counts();
        step(10);
        check("release_no_pulse", n_td + n_xp + n_tp + n_fg + n_sf + n_rej, 0);
    endtask

    initial begin
        reset = 1'b0;
        btn_touchdown = 0; btn_extra_point = 0; btn_two_point = 0;
        btn_field_goal = 0; btn_safety = 0;
        clear_counts();

        // Reset state
        step(3);
        check("reset_outputs", outs_vec(), 0);
        reset = 1'b1;
        step(4);
        check("idle_outputs", outs_vec(), 0);
        $display("txn reset: outputs %b", outs_vec());

        // Held touchdown in NORMAL
        clear_counts();
        btn_touchdown = 1;
        step(20);
        check("td_count", n_td, 1);
        check("td_edge", e_td, 7);
        check("td_cp_edge", e_cp, 7);
        check("td_others", n_xp + n_tp + n_fg + n_sf + n_rej, 0);
        $display("txn touchdown hold: pulses %0d at edge %0d", n_td, e_td);
        release_all();
        check("td_cp_after", int'(conversion_pending), 1);

        // Three-cycle field-goal glitch in CONVERSION: ignored, not rejected
        clear_counts();
        btn_field_goal = 1;
        step(3);
        btn_field_goal = 0;
        step(12);
        check("glitch_fg", n_fg, 0);
        check("glitch_rej", n_rej, 0);
        check("glitch_cp", int'(conversion_pending), 1);
        $display("txn fg glitch: fg %0d rej %0d", n_fg, n_rej);

        // Two-point and safety together in CONVERSION
        clear_counts();
        btn_two_point = 1;
        btn_safety    = 1;
        step(12);
        check("tp_count", n_tp, 1);
        check("tp_edge", e_tp, 7);
        check("tp_sf_dropped", n_sf, 0);
        check("tp_rej", n_rej, 0);
        check("tp_cp", int'(conversion_pending), 0);
        $display("txn two-point+safety: tp %0d sf %0d", n_tp, n_sf);
        release_all();

        // Extra point in NORMAL is illegal
        clear_counts();
        btn_extra_point = 1;
        step(12);
        check("xp_rej_count", n_rej, 1);
        check("xp_rej_edge", e_rej, 7);
        check("xp_no_score", n_td + n_xp + n_tp + n_fg + n_sf, 0);
        check("xp_cp", int'(conversion_pending), 0);
        $display("txn illegal extra-point: rej %0d", n_rej);
        release_all();

        // Field goal in NORMAL is legal
        clear_counts();
        btn_field_goal = 1;
        step(12);
        check("fg_count", n_fg, 1);
        check("fg_edge", e_fg, 7);
        check("fg_cp", int'(conversion_pending), 0);
        $display("txn field goal: fg %0d at edge %0d", n_fg, e_fg);
        release_all();

        // Touchdown and field goal together in NORMAL
        clear_counts();
        btn_touchdown  = 1;
        btn_field_goal = 1;
        step(12);
        check("tdfg_td", n_td, 1);
        check("tdfg_fg_dropped", n_fg, 0);
        check("tdfg_rej", n_rej, 0);
        check("tdfg_cp", int'(conversion_pending), 1);
        $display("txn touchdown+fg: td %0d fg %0d", n_td, n_fg);
        release_all();

        // Reset during CONVERSION with safety held through release
        btn_safety = 1;
        step(3);
        reset = 1'b0;
        #1;
        check("rst_cp_immediate", int'(conversion_pending), 0);
        check("rst_outs_immediate", outs_vec(), 0);
        step(2);
        reset = 1'b1;
        clear_counts();
        step(16);
        check("rst_sf_count", n_sf, 1);
        check("rst_sf_edge", e_sf, 9);
        check("rst_rej", n_rej, 0);
        check("rst_cp", int'(conversion_pending), 0);
        $display("txn reset in conversion: sf %0d at edge %0d", n_sf, e_sf);
        release_all();

        check("one_hot_outputs", n_multi, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
